hyperbus_tf_sched: RTL and testbench



---
 rtl/hyperbus_tf_sched.sv | 188 ++++++++++++++++++
 tb/tb_hyperbus_tf_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_tf_sched.sv
// Hyperbus transfer scheduler: round-robin between two requesters, linear burst splitting, PHY recovery gap.
// Optional statistics counters are enabled with `define HYPERBUS_SCHED_STATS_EN.

package hyperbus_tf_sched_pkg;

    typedef struct packed {
        logic        write;
        logic        addr_space;
        logic        burst_type;   // 1 = linear, 0 = wrapped
        logic [31:0] address;
        logic [15:0] burst;
    } hyper_tf_t;

    typedef struct packed {
        logic [15:0] t_burst_max;
        logic [3:0]  t_read_write_recovery;
    } hyper_cfg_t;

endpackage

module hyperbus_tf_sched
    import hyperbus_tf_sched_pkg::*;
#(
    parameter int unsigned NumReq = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  hyper_cfg_t              cfg_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  hyper_tf_t [NumReq-1:0]  req_tf_i,
    output logic                    phy_valid_o,
    input  logic                    phy_ready_i,
    output hyper_tf_t               phy_tf_o,
    input  logic                    phy_done_i,
    output logic                    gnt_id_o,
    output logic                    busy_o,
`ifdef HYPERBUS_SCHED_STATS_EN
    output logic [31:0]             sched_chunks_o,
    output logic [31:0]             sched_splits_o,
`endif
    output logic                    tf_done_o
);

    // Handshakes: a transfer moves when valid and ready are both high on a rising edge.
    // valid never waits on ready; once raised, valid and its payload hold until accepted.

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone,
        StRecover
    } state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        gnt_q, gnt_d;
    logic        busy_q, busy_d;
    hyper_tf_t   cur_q, cur_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        has_req;
    logic        gnt_sel;
    logic [15:0] chunk;
    logic [15:0] remaining;
    logic [31:0] addr_step;

    assign has_req = |req_valid_i;
    assign gnt_sel = req_valid_i[ptr_q] ? ptr_q : ~ptr_q;

    // Wrapped bursts and an unlimited max are never split.
    always_comb begin
        chunk = cur_q.burst;
        if ((cfg_i.t_burst_max != 16'd0) && cur_q.burst_type &&
            (cur_q.burst > cfg_i.t_burst_max)) begin
            chunk = cfg_i.t_burst_max;
        end
    end

    assign remaining = cur_q.burst - chunk;
    assign addr_step = {15'd0, chunk, 1'b0};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        req_ready_o = '0;
        phy_valid_o = 1'b0;
        phy_tf_o    = '0;
        tf_done_o   = 1'b0;

        case (state_q)
            StIdle: begin
                if (has_req) begin
                    req_ready_o[gnt_sel] = 1'b1;
                    cur_d   = req_tf_i[gnt_sel];
                    gnt_d   = gnt_sel;
                    busy_d  = 1'b1;
                    ptr_d   = ~gnt_sel;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                phy_valid_o    = 1'b1;
                phy_tf_o       = cur_q;
                phy_tf_o.burst = chunk;
                if (phy_ready_i) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (phy_done_i) begin
                    cur_d.address = cur_q.address + addr_step;
                    cur_d.burst   = remaining;
                    if (remaining == 16'd0) begin
                        tf_done_o = 1'b1;
                        busy_d    = 1'b0;
                    end
                    // Recover lasts max(1, t_read_write_recovery) cycles.
                    cnt_d   = (cfg_i.t_read_write_recovery == 4'd0) ? 4'd0
                            : cfg_i.t_read_write_recovery - 4'd1;
                    state_d = StRecover;
                end
            end
            StRecover: begin
                if (cnt_q == 4'd0) begin
                    state_d = (cur_q.burst != 16'd0) ? StIssue : StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            busy_q  <= 1'b0;
            cur_q   <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_id_o = gnt_q;
    assign busy_o   = busy_q;

`ifdef HYPERBUS_SCHED_STATS_EN
    logic [31:0] chunks_q;
    logic [31:0] splits_q;
    logic        latch_split;

    assign latch_split = (state_q == StIdle) && has_req &&
                         req_tf_i[gnt_sel].burst_type &&
                         (cfg_i.t_burst_max != 16'd0) &&
                         (req_tf_i[gnt_sel].burst > cfg_i.t_burst_max);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chunks_q <= 32'd0;
            splits_q <= 32'd0;
        end else begin
            if (phy_valid_o && phy_ready_i) begin
                chunks_q <= chunks_q + 32'd1;
            end
            if (latch_split) begin
                splits_q <= splits_q + 32'd1;
            end
        end
    end

    assign sched_chunks_o = chunks_q;
    assign sched_splits_o = splits_q;
`endif

endmodule

// File: tb/tb_hyperbus_tf_sched.sv
// Directed bench for hyperbus_tf_sched: inputs driven on the falling edge, outputs checked 1ns later.
module tb_hyperbus_tf_sched;
  import hyperbus_tf_sched_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  hyper_cfg_t      cfg;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  hyper_tf_t [1:0] req_tf;
  logic            phy_valid;
  logic            phy_ready;
  hyper_tf_t       phy_tf;
  logic            phy_done;
  logic            gnt_id;
  logic            busy;
  logic            tf_done;
`ifdef HYPERBUS_SCHED_STATS_EN
  logic [31:0]     sched_chunks;
  logic [31:0]     sched_splits;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hyperbus_tf_sched #(.NumReq(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_i       (cfg),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_tf_i    (req_tf),
    .phy_valid_o (phy_valid),
    .phy_ready_i (phy_ready),
    .phy_tf_o    (phy_tf),
    .phy_done_i  (phy_done),
    .gnt_id_o    (gnt_id),
    .busy_o      (busy),
`ifdef HYPERBUS_SCHED_STATS_EN
    .sched_chunks_o (sched_chunks),
    .sched_splits_o (sched_splits),
`endif
    .tf_done_o   (tf_done)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; cfg = '0; req_valid = 2'b00; req_tf = '0;
    phy_ready = 1'b0; phy_done = 1'b0;
    tick; tick;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_checks++; if (phy_valid !== 1'b0) begin n_fail++; $display("FAIL reset_phy_valid: got %b want 0", phy_valid); end
    n_checks++; if (phy_tf !== '0) begin n_fail++; $display("FAIL reset_phy_tf: got %h want 0", phy_tf); end
    n_checks++; if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_id: got %b want 0", gnt_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (tf_done !== 1'b0) begin n_fail++; $display("FAIL reset_tf_done: got %b want 0", tf_done); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    hyper_tf_t t;
    cfg.t_burst_max = 16'd0; cfg.t_read_write_recovery = 4'd0; phy_ready = 1'b1;
    t = '0; t.burst_type = 1'b1; t.address = 32'h100; t.burst = 16'd16;
    req_tf[0] = t; req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
    tick; req_valid = 2'b00; #1;
    n_checks++; if (busy !== 1'b1 || gnt_id !== 1'b0) begin n_fail++; $display("FAIL single_busy_gnt: got %b/%b want 1/0", busy, gnt_id); end
    n_checks++; if (phy_valid !== 1'b1) begin n_fail++; $display("FAIL single_phy_valid: got %b want 1", phy_valid); end
    n_checks++; if (phy_tf.address !== 32'h100 || phy_tf.burst !== 16'd16) begin n_fail++; $display("FAIL single_tf: got %h/%0d want 100/16", phy_tf.address, phy_tf.burst); end
    tick; phy_done = 1'b1; #1;
    n_checks++; if (tf_done !== 1'b1) begin n_fail++; $display("FAIL single_tf_done: got %b want 1", tf_done); end
    n_checks++; if (phy_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_low_wait: got %b want 0", phy_valid); end
    tick; phy_done = 1'b0; #1;
    n_checks++; if (busy !== 1'b0 || tf_done !== 1'b0) begin n_fail++; $display("FAIL single_busy_clear: got busy %b done %b want 0/0", busy, tf_done); end
    tick; tick;
  endtask

  task automatic test_split;
    hyper_tf_t t;
    int gap;
    cfg.t_burst_max = 16'd16; cfg.t_read_write_recovery = 4'd3; phy_ready = 1'b1;
    t = '0; t.burst_type = 1'b1; t.address = 32'h1000; t.burst = 16'd40;
    req_tf[0] = t; req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL split_ready: got %b want 01", req_ready); end
    tick; req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (phy_valid !== 1'b1) begin n_fail++; $display("FAIL split_valid_%0d: got %b want 1", k, phy_valid); end
      n_checks++;
      if (phy_tf.address !== 32'h1000 + 32'(k) * 32'h20 || phy_tf.burst !== ((k < 2) ? 16'd16 : 16'd8)) begin
        n_fail++; $display("FAIL split_tf_%0d: got %h/%0d want %h/%0d", k, phy_tf.address, phy_tf.burst,
                           32'h1000 + 32'(k) * 32'h20, (k < 2) ? 16 : 8);
      end
      tick; phy_done = 1'b1; #1;
      n_checks++; if (tf_done !== (k == 2)) begin n_fail++; $display("FAIL split_done_%0d: got %b want %b", k, tf_done, (k == 2)); end
      tick; phy_done = 1'b0; gap = 1; #1;
      if (k < 2) begin
        while (phy_valid !== 1'b1 && gap < 20) begin tick; gap++; #1; end
        n_checks++; if (gap !== 4) begin n_fail++; $display("FAIL split_gap_%0d: got %0d cycles want 4", k, gap); end
      end else begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL split_busy_clear: got %b want 0", busy); end
      end
    end
    tick; tick; tick; tick;
    #1;
    n_checks++; if (phy_valid !== 1'b0 || tf_done !== 1'b0) begin n_fail++; $display("FAIL split_idle_after: got valid %b done %b want 0/0", phy_valid, tf_done); end
    tick;
  endtask

  task automatic test_wrapped;
    hyper_tf_t t;
    cfg.t_burst_max = 16'd16; cfg.t_read_write_recovery = 4'd0; phy_ready = 1'b1;
    t = '0; t.burst_type = 1'b0; t.address = 32'h2000; t.burst = 16'd40;
    req_tf[0] = t; req_valid = 2'b01;
    tick; req_valid = 2'b00; #1;
    n_checks++; if (phy_tf.burst !== 16'd40 || phy_tf.address !== 32'h2000) begin n_fail++; $display("FAIL wrapped_tf: got %h/%0d want 2000/40", phy_tf.address, phy_tf.burst); end
    tick; phy_done = 1'b1; #1;
    n_checks++; if (tf_done !== 1'b1) begin n_fail++; $display("FAIL wrapped_done: got %b want 1", tf_done); end
    tick; phy_done = 1'b0; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrapped_busy: got %b want 0", busy); end
    tick; tick;
  endtask

  task automatic test_back_to_back;
    hyper_tf_t t0, t1;
    logic exp;
    rst = 1'b1; tick; rst = 1'b0;
    cfg.t_burst_max = 16'd0; cfg.t_read_write_recovery = 4'd0; phy_ready = 1'b1;
    t0 = '0; t0.burst_type = 1'b1; t0.address = 32'hA00; t0.burst = 16'd4;
    t1 = '0; t1.burst_type = 1'b1; t1.address = 32'hB00; t1.burst = 16'd4; t1.write = 1'b1;
    req_tf[0] = t0; req_tf[1] = t1; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp = i[0];
      #1;
      n_checks++; if (req_ready !== (exp ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_ready_%0d: got %b want %b", i, req_ready, exp ? 2'b10 : 2'b01); end
      tick; #1;
      n_checks++; if (gnt_id !== exp) begin n_fail++; $display("FAIL rr_gnt_%0d: got %b want %b", i, gnt_id, exp); end
      n_checks++; if (phy_tf.address !== (exp ? 32'hB00 : 32'hA00)) begin n_fail++; $display("FAIL rr_addr_%0d: got %h want %h", i, phy_tf.address, exp ? 32'hB00 : 32'hA00); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_ready_issue_%0d: got %b want 00", i, req_ready); end
      tick; phy_done = 1'b1; #1;
      n_checks++; if (tf_done !== 1'b1 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_done_%0d: got done %b ready %b want 1/00", i, tf_done, req_ready); end
      tick; phy_done = 1'b0; #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_ready_recover_%0d: got %b want 00", i, req_ready); end
      tick;
    end
    req_valid = 2'b00;
    tick;
  endtask

  task automatic test_stall;
    hyper_tf_t t;
    cfg.t_burst_max = 16'd0; cfg.t_read_write_recovery = 4'd0; phy_ready = 1'b0;
    t = '0; t.burst_type = 1'b1; t.write = 1'b1; t.addr_space = 1'b1; t.address = 32'h3000; t.burst = 16'd8;
    req_tf[0] = t; req_valid = 2'b01;
    tick; req_valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (phy_valid !== 1'b1 || phy_tf !== t) begin n_fail++; $display("FAIL stall_hold_%0d: got %b/%h want 1/%h", i, phy_valid, phy_tf, t); end
      tick;
    end
    phy_ready = 1'b1; #1;
    n_checks++; if (phy_valid !== 1'b1) begin n_fail++; $display("FAIL stall_accept_valid: got %b want 1", phy_valid); end
    tick; #1;
    n_checks++; if (phy_valid !== 1'b0) begin n_fail++; $display("FAIL stall_after_accept: got %b want 0", phy_valid); end
    phy_done = 1'b1; #1;
    n_checks++; if (tf_done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", tf_done); end
    tick; phy_done = 1'b0; tick; tick;
  endtask

  task automatic test_reset_mid;
    hyper_tf_t t;
    cfg.t_burst_max = 16'd16; cfg.t_read_write_recovery = 4'd0; phy_ready = 1'b1;
    t = '0; t.burst_type = 1'b1; t.address = 32'h4000; t.burst = 16'd40;
    req_tf[0] = t; req_valid = 2'b01;
    tick; req_valid = 2'b00; #1;
    n_checks++; if (phy_tf.burst !== 16'd16) begin n_fail++; $display("FAIL rmid_chunk1: got %0d want 16", phy_tf.burst); end
    tick; phy_done = 1'b1;
    tick; phy_done = 1'b0;
    tick; #1;
    n_checks++; if (phy_valid !== 1'b1 || phy_tf.address !== 32'h4020) begin n_fail++; $display("FAIL rmid_chunk2: got %b/%h want 1/4020", phy_valid, phy_tf.address); end
    tick; rst = 1'b1;
    tick; #1;
    n_checks++; if (req_ready !== 2'b00 || phy_valid !== 1'b0 || phy_tf !== '0) begin n_fail++; $display("FAIL rmid_outputs: got ready %b valid %b tf %h want 00/0/0", req_ready, phy_valid, phy_tf); end
    n_checks++; if (gnt_id !== 1'b0 || busy !== 1'b0 || tf_done !== 1'b0) begin n_fail++; $display("FAIL rmid_status: got gnt %b busy %b done %b want 0/0/0", gnt_id, busy, tf_done); end
    rst = 1'b0;
    t.address = 32'h5000; t.burst = 16'd4; req_tf[0] = t;
    t.address = 32'h6000; req_tf[1] = t;
    req_valid = 2'b11; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_regrant_ready: got %b want 01", req_ready); end
    tick; req_valid = 2'b00; #1;
    n_checks++; if (gnt_id !== 1'b0 || busy !== 1'b1 || phy_tf.address !== 32'h5000) begin n_fail++; $display("FAIL rmid_regrant: got gnt %b busy %b addr %h want 0/1/5000", gnt_id, busy, phy_tf.address); end
    tick; phy_done = 1'b1; #1;
    n_checks++; if (tf_done !== 1'b1) begin n_fail++; $display("FAIL rmid_final_done: got %b want 1", tf_done); end
    tick; phy_done = 1'b0; tick; tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_split;
    test_wrapped;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
